// File: rtl/im_loader.sv
// rtl/im_loader.sv - instruction ROM image loader with XOR checksum and CPU hold
//
// Purpose:
//   Accepts a program image as a valid/ready word stream framed as
//   { N, word[0] .. word[N-1], C } and writes word[i] to the instruction
//   memory at word address i. C must equal the XOR of all N words. The CPU
//   is held in reset until an image has loaded with a matching checksum.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin a load; honoured only in IDLE, DONE or ERR
//   in_valid   in   stream word valid
//   in_data    in   stream word
//   in_ready   out  loader accepts in_data this cycle (state-only decode)
//   w_addr     out  instruction memory write address (word index)
//   w_data     out  instruction memory write data
//   w_en       out  instruction memory write strobe, one cycle per word
//   busy       out  loading in progress (HDR, LOAD or CHK)
//   done       out  image loaded and checksum matched
//   err        out  bad length or checksum mismatch
//   cpu_hold   out  keep CPU in reset; low only in DONE

module im_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              w_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  // Largest legal image length, compared against the full header word so
  // that headers with any upper bit set are rejected.
  localparam logic [DATA_W-1:0] DEPTH = DATA_W'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  // addr/cnt carry one extra bit so a 1024-word image counts to 1024
  // without wrapping back onto address 0.
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;

  logic                xfer;
  logic                hdr_bad;

  assign hdr_bad = (in_data == '0) || (in_data > DEPTH);
  assign xfer    = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    in_ready = 1'b0;
    w_en     = 1'b0;
    w_addr   = '0;
    w_data   = '0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (hdr_bad) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = in_data[ADDR_W:0];
            addr_d  = '0;
            acc_d   = '0;
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        // Write port follows the stream directly; the strobe is the
        // handshake itself so a gap cycle never writes.
        w_addr   = addr_q[ADDR_W-1:0];
        w_data   = in_data;
        w_en     = xfer;
        if (xfer) begin
          acc_d  = acc_q ^ in_data;
          addr_d = addr_q + ONE;
          if (addr_q == cnt_q - ONE) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        in_ready = 1'b1;
        if (xfer) begin
          state_d = (in_data == acc_q) ? S_DONE : S_ERR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized self-checking bench for im_loader

module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [9:0]  w_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int n_checks = 0;
  int n_fail   = 0;

  // observed write log
  int unsigned wr_a[$];
  logic [31:0] wr_d[$];

  // stimulus image and model expectations
  logic [31:0] img_q[$];
  int unsigned exp_a[$];
  logic [31:0] exp_d[$];
  bit          exp_done;
  bit          exp_err;

  im_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wr_a.push_back(w_addr);
      wr_d.push_back(w_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: frame { n, img_q[0..n-1], c } -> writes and outcome.
  task automatic model_frame(input logic [31:0] n, input logic [31:0] c);
    logic [31:0] x;
    exp_a.delete();
    exp_d.delete();
    exp_done = 0;
    exp_err  = 0;
    if (n < 1 || n > 1024) begin
      exp_err = 1;
    end else begin
      x = 0;
      for (int i = 0; i < int'(n); i++) begin
        exp_a.push_back(i);
        exp_d.push_back(img_q[i]);
        x = x ^ img_q[i];
      end
      exp_done = (x == c);
      exp_err  = !exp_done;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gaps, input bit start_too);
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    start    = start_too;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic pulse_start();
    wr_a.delete();
    wr_d.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gap_fixed=1: exactly max_gap idle cycles before every word after the header
  task automatic run_frame(input logic [31:0] n, input logic [31:0] c, input int max_gap,
                           input bit gap_fixed, input bit poke_start);
    int gaps;
    int poke_at;
    pulse_start();
    send_word(n, 0, 0);
    if (n >= 1 && n <= 1024) begin
      poke_at = poke_start ? int'($urandom_range(0, int'(n) - 1)) : -1;
      for (int i = 0; i < int'(n); i++) begin
        gaps = gap_fixed ? max_gap : int'($urandom_range(0, max_gap));
        send_word(img_q[i], gaps, i == poke_at);
      end
      gaps = gap_fixed ? max_gap : int'($urandom_range(0, max_gap));
      send_word(c, gaps, 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, w_en, busy, done, err, cpu_hold} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/wen/busy/done/err/hold=%b want 000001",
               {in_ready, w_en, busy, done, err, cpu_hold});
    end
    n_checks++;
    if (w_addr !== 10'd0 || w_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wport: got addr=%0d data=%h want 0/0", w_addr, w_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    img_q = '{32'h3c010001, 32'h34210002, 32'h00000000};
    model_frame(3, 32'h08200003);
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_hdr: got busy=%b rdy=%b hold=%b want 1/1/1", busy, in_ready, cpu_hold);
    end
    send_word(32'd3, 0, 0);
    for (int i = 0; i < 3; i++) send_word(img_q[i], 0, 0);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_pre_chk: got done=%b busy=%b want 0/1", done, busy);
    end
    send_word(32'h08200003, 0, 0);
    n_checks++;
    if (wr_a.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL nom_wcount: got %0d want %0d", wr_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        n_checks++;
        if (wr_a[i] != exp_a[i] || wr_d[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL nom_write[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_checks++;
    if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, !exp_done, 1'b0}) begin
      n_fail++;
      $display("FAIL nom_status: got done/err/hold/busy=%b want %b",
               {done, err, cpu_hold, busy}, {exp_done, exp_err, !exp_done, 1'b0});
    end
  endtask

  task automatic test_backpressure();
    img_q = '{32'h3c010001, 32'h34210002, 32'h00000000};
    model_frame(3, 32'h08200003);
    run_frame(3, 32'h08200003, 2, 1, 0);
    n_checks++;
    if (wr_a.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL bp_wcount: got %0d want %0d", wr_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        n_checks++;
        if (wr_a[i] != exp_a[i] || wr_d[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL bp_write[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_checks++;
    if ({done, err, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
      n_fail++;
      $display("FAIL bp_status: got done/err/hold=%b want %b", {done, err, cpu_hold}, {exp_done, exp_err, !exp_done});
    end
  endtask

  task automatic test_bad_checksum();
    img_q = '{32'h11111111, 32'h22222222};
    model_frame(2, 32'h0);
    run_frame(2, 32'h0, 0, 1, 0);
    n_checks++;
    if ({done, err, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
      n_fail++;
      $display("FAIL badck_status: got done/err/hold=%b want %b", {done, err, cpu_hold}, {exp_done, exp_err, !exp_done});
    end
    n_checks++;
    if (wr_a.size() != 2 || wr_a[0] != 0 || wr_a[1] != 1 ||
        wr_d[0] !== 32'h11111111 || wr_d[1] !== 32'h22222222) begin
      n_fail++;
      $display("FAIL badck_writes: got %0d writes, want 2 at 0/1 with 11111111/22222222", wr_a.size());
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] hdrs [2];
    logic [31:0] w;
    hdrs[0] = 32'd0;
    hdrs[1] = 32'd1025;
    for (int k = 0; k < 2; k++) begin
      run_frame(hdrs[k], 32'h0, 0, 1, 0);
      n_checks++;
      if ({err, done, busy, in_ready, cpu_hold} !== 5'b10001 || wr_a.size() != 0) begin
        n_fail++;
        $display("FAIL badlen_%0d: got err/done/busy/rdy/hold=%b writes=%0d want 10001 writes=0",
                 hdrs[k], {err, done, busy, in_ready, cpu_hold}, wr_a.size());
      end
    end
    w = $urandom;
    img_q = '{w};
    model_frame(1, w);
    run_frame(1, w, 0, 1, 0);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || wr_a.size() != 1 || wr_d[0] !== w) begin
      n_fail++;
      $display("FAIL badlen_recover: got done=%b err=%b writes=%0d want 1/0/1", done, err, wr_a.size());
    end
  endtask

  task automatic test_full_depth();
    int extra_zero;
    img_q.delete();
    for (int i = 0; i < 1024; i++) img_q.push_back(i);
    model_frame(1024, 32'h0);
    run_frame(1024, 32'h0, 0, 1, 0);
    n_checks++;
    if (wr_a.size() != 1024) begin
      n_fail++;
      $display("FAIL full_wcount: got %0d want 1024", wr_a.size());
    end else begin
      n_checks++;
      if (wr_a[1023] != 1023) begin
        n_fail++;
        $display("FAIL full_last_addr: got %0d want 1023", wr_a[1023]);
      end
      extra_zero = 0;
      for (int i = 1; i < 1024; i++) if (wr_a[i] == 0) extra_zero++;
      n_checks++;
      if (extra_zero != 0) begin
        n_fail++;
        $display("FAIL full_wrap: got %0d later writes to address 0 want 0", extra_zero);
      end
      for (int i = 0; i < 1024; i++) begin
        if (wr_a[i] != exp_a[i] || wr_d[i] !== exp_d[i]) begin
          n_checks++;
          n_fail++;
          $display("FAIL full_write[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_checks++;
    if ({done, err, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
      n_fail++;
      $display("FAIL full_status: got done/err/hold=%b want %b", {done, err, cpu_hold}, {exp_done, exp_err, !exp_done});
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] x;
    img_q.delete();
    for (int i = 0; i < 10; i++) img_q.push_back($urandom);
    pulse_start();
    send_word(32'd10, 0, 0);
    for (int i = 0; i < 5; i++) send_word(img_q[i], 0, 0);
    in_valid = 1'b1;
    in_data  = img_q[5];
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, w_en, busy, done, err, cpu_hold} !== 6'b000001 || w_addr !== 10'd0 || w_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got rdy/wen/busy/done/err/hold=%b addr=%0d data=%h want 000001/0/0",
               {in_ready, w_en, busy, done, err, cpu_hold}, w_addr, w_data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (wr_a.size() != 5) begin
      n_fail++;
      $display("FAIL midrst_writes: got %0d want 5", wr_a.size());
    end
    reset = 1'b0;
    @(posedge clk); #1;
    img_q = '{$urandom, $urandom};
    x = img_q[0] ^ img_q[1];
    model_frame(2, x);
    run_frame(2, x, 1, 0, 0);
    n_checks++;
    if (done !== exp_done || wr_a.size() != 2 || wr_a[0] != 0 || wr_a[1] != 1) begin
      n_fail++;
      $display("FAIL midrst_reload: got done=%b writes=%0d want %b/2 from 0", done, wr_a.size(), exp_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [31:0] c;
    int          sel;
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: n = 32'd0;
        1: n = ($urandom_range(0, 1) != 0) ? 32'd1025 : 32'hffff_ffff;
        default: n = $urandom_range(1, 24);
      endcase
      img_q.delete();
      c = 0;
      if (n >= 1 && n <= 1024) begin
        for (int i = 0; i < int'(n); i++) begin
          img_q.push_back($urandom);
          c = c ^ img_q[i];
        end
      end
      if ($urandom_range(0, 2) == 0) c = c ^ (32'h1 << $urandom_range(0, 31));
      model_frame(n, c);
      run_frame(n, c, 3, 0, $urandom_range(0, 1) != 0);
      n_checks++;
      if (wr_a.size() != exp_a.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_wcount: got %0d want %0d", it, wr_a.size(), exp_a.size());
      end else begin
        for (int i = 0; i < exp_a.size(); i++) begin
          n_checks++;
          if (wr_a[i] != exp_a[i] || wr_d[i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL rnd%0d_write[%0d]: got %0d/%h want %0d/%h", it, i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
          end
        end
      end
      n_checks++;
      if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, !exp_done, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd%0d_status: got done/err/hold/busy=%b want %b", it,
                 {done, err, cpu_hold, busy}, {exp_done, exp_err, !exp_done, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_bad_checksum();
    test_bad_length();
    test_full_depth();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
